instr_fetch: RTL and testbench

Instruction fetch stage of the single-issue core, directly upstream of `controlunit`. Generates sequential PCs, issues requests to instruction memory over a grant/response-valid interface with up to two requests in flight, buffers returned words in a 2-entry queue, and presents the head instruction with its PC, the `opcode`/`funct` fields and an illegal-opcode flag to the decode stage under valid/ready. Redirect (flush) restarts fetch at a new PC and discards in-flight responses.

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_fifo.sv | 54 +++++
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode constants: opcode encodings, field positions, PC increment.
package instr_fetch_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000001,
        OP_SW    = 6'b000010,
        OP_LW    = 6'b000100
    } opcode_e;

    localparam logic [5:0]  FUNCT_ADD = 6'b100000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Two-entry queue with push/pop/clear; push into a full queue is accepted only
// alongside a pop.
module fetch_fifo #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= RESET_VAL;
            mem_q[1] <= RESET_VAL;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC generation, credit-limited imem requests,
// 2-entry instruction queue towards decode, flush/redirect with response discard.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = instr_fetch_pkg::PC_STEP,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        instr_fetch_clk,
    input  logic        instr_fetch_rst_n,
    output logic        instr_fetch_imem_req,
    output logic [31:0] instr_fetch_imem_addr,
    input  logic        instr_fetch_imem_gnt,
    input  logic        instr_fetch_imem_rvalid,
    input  logic [31:0] instr_fetch_imem_rdata,
    input  logic        instr_fetch_flush,
    input  logic [31:0] instr_fetch_redirect_pc,
    output logic        instr_fetch_id_valid,
    input  logic        instr_fetch_id_ready,
    output logic [31:0] instr_fetch_id_instr,
    output logic [31:0] instr_fetch_id_pc,
    output logic [5:0]  instr_fetch_opcode,
    output logic [5:0]  instr_fetch_funct,
    output logic        instr_fetch_illegal
);
    import instr_fetch_pkg::*;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  outst_q, outst_d;
    logic [1:0]  discard_q, discard_d;
    logic [1:0]  iq_count, pcq_count;
    logic [63:0] iq_head;
    logic [31:0] rsp_pc;
    logic [2:0]  credits_used;
    logic        handshake, accept, pop;

    // Credits count both in-flight requests and buffered words, so a response
    // can never land in a full queue.
    assign credits_used = {1'b0, outst_q} + {1'b0, iq_count};
    assign instr_fetch_imem_req  = instr_fetch_rst_n && !instr_fetch_flush &&
                                   (credits_used < 3'(DEPTH));
    assign instr_fetch_imem_addr = pc_q;

    assign handshake = instr_fetch_imem_req && instr_fetch_imem_gnt;
    assign accept    = instr_fetch_imem_rvalid && !instr_fetch_flush &&
                       (discard_q == 2'd0) && (pcq_count != 2'd0);
    assign pop       = instr_fetch_id_valid && instr_fetch_id_ready && !instr_fetch_flush;

    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q + 2'(handshake) - 2'(instr_fetch_imem_rvalid);
        discard_d = discard_q;
        if (instr_fetch_flush) begin
            pc_d      = instr_fetch_redirect_pc;
            discard_d = outst_q - 2'(instr_fetch_imem_rvalid);
        end else begin
            if (handshake) begin
                pc_d = pc_q + PC_STEP;
            end
            if (instr_fetch_imem_rvalid && (discard_q != 2'd0)) begin
                discard_d = discard_q - 2'd1;
            end
        end
    end

    always_ff @(posedge instr_fetch_clk or negedge instr_fetch_rst_n) begin
        if (!instr_fetch_rst_n) begin
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH     (32),
        .RESET_VAL ('0)
    ) u_pc_queue (
        .clk_i   (instr_fetch_clk),
        .rst_ni  (instr_fetch_rst_n),
        .push_i  (handshake),
        .pop_i   (accept),
        .clear_i (instr_fetch_flush),
        .data_i  (pc_q),
        .head_o  (rsp_pc),
        .count_o (pcq_count)
    );

    fetch_fifo #(
        .WIDTH     (64),
        .RESET_VAL ({32'h0000_0000, RESET_PC})
    ) u_instr_queue (
        .clk_i   (instr_fetch_clk),
        .rst_ni  (instr_fetch_rst_n),
        .push_i  (accept),
        .pop_i   (pop),
        .clear_i (instr_fetch_flush),
        .data_i  ({instr_fetch_imem_rdata, rsp_pc}),
        .head_o  (iq_head),
        .count_o (iq_count)
    );

    assign instr_fetch_id_valid = (iq_count != 2'd0);
    assign instr_fetch_id_instr = iq_head[63:32];
    assign instr_fetch_id_pc    = iq_head[31:0];
    assign instr_fetch_opcode   = instr_fetch_id_instr[OPCODE_MSB:OPCODE_LSB];
    assign instr_fetch_funct    = instr_fetch_id_instr[FUNCT_MSB:FUNCT_LSB];
    assign instr_fetch_illegal  = instr_fetch_id_valid && !is_legal_opcode(instr_fetch_opcode);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model plus expected-stream scoreboard of PCs.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk, rst_n;
    logic        req, gnt, rvalid, flush, id_ready;
    logic [31:0] addr, rdata, redirect_pc;
    logic        id_valid, illegal;
    logic [31:0] id_instr, id_pc;
    logic [5:0]  opcode, funct;

    instr_fetch #(
        .RESET_PC (RST_PC),
        .PC_STEP  (32'd4),
        .DEPTH    (2)
    ) dut (
        .instr_fetch_clk         (clk),
        .instr_fetch_rst_n       (rst_n),
        .instr_fetch_imem_req    (req),
        .instr_fetch_imem_addr   (addr),
        .instr_fetch_imem_gnt    (gnt),
        .instr_fetch_imem_rvalid (rvalid),
        .instr_fetch_imem_rdata  (rdata),
        .instr_fetch_flush       (flush),
        .instr_fetch_redirect_pc (redirect_pc),
        .instr_fetch_id_valid    (id_valid),
        .instr_fetch_id_ready    (id_ready),
        .instr_fetch_id_instr    (id_instr),
        .instr_fetch_id_pc       (id_pc),
        .instr_fetch_opcode      (opcode),
        .instr_fetch_funct       (funct),
        .instr_fetch_illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int unsigned rdy;
    } mreq_t;

    mreq_t       mq[$];
    int unsigned cyc = 0;
    int unsigned checks = 0, passes = 0, fails = 0;
    logic [31:0] exp_pc = RST_PC, issue_pc = RST_PC;

    bit want_rst = 1'b0;
    bit gnt_fix = 1'b1, gnt_rand = 1'b0;
    bit hold_resp = 1'b0, resp_rand = 1'b0;
    bit ready_fix = 1'b1, ready_rand = 1'b0;
    bit lat_rand = 1'b0;
    int unsigned lat = 1;

    logic        s_req, s_hs, s_valid;
    logic [31:0] s_pc, s_addr, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h200) return 32'hFC00_0000;
        if (a == 32'h204) return {6'b000100, 26'h012_3456};
        h = a * 32'h9E37_79B1 + 32'h7F4A_7C15;
        case (h[1:0])
            2'd0:    return {6'b000001, h[27:2]};
            2'd1:    return {6'b000100, h[27:2]};
            2'd2:    return {6'b000010, h[27:2]};
            default: return h;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit do_flush, input logic [31:0] rpc);
        bit          rv;
        logic [31:0] w;
        logic [5:0]  op;
        @(negedge clk);
        cyc++;
        rst_n       = want_rst;
        flush       = do_flush;
        redirect_pc = do_flush ? rpc : $urandom;
        gnt         = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_fix;
        id_ready    = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
        rv = rst_n && !hold_resp && (mq.size() > 0) && (mq[0].rdy <= cyc) &&
             (!resp_rand || ($urandom_range(0, 3) != 0));
        rvalid = rv;
        rdata  = rv ? mq[0].data : $urandom;
        #4;
        s_req = req; s_hs = req && gnt; s_valid = id_valid;
        s_pc = id_pc; s_addr = addr; s_instr = id_instr;
        if (!rst_n) begin
            chk("rst_req", 32'(req), 0);
            chk("rst_valid", 32'(id_valid), 0);
            chk("rst_pc", id_pc, RST_PC);
            chk("rst_instr", id_instr, 0);
            mq.delete();
            exp_pc   = RST_PC;
            issue_pc = RST_PC;
            return;
        end
        if (rv) void'(mq.pop_front());
        if (do_flush) chk("req_in_flush", 32'(req), 0);
        if (req && gnt) begin
            chk("imem_addr", addr, issue_pc);
            mq.push_back('{data: mem_word(addr),
                           rdy: cyc + (lat_rand ? $urandom_range(1, 3) : lat)});
            issue_pc = issue_pc + 32'd4;
            chk("inflight_le2", 32'(mq.size() <= 2), 1);
        end
        if (id_valid) begin
            w  = mem_word(exp_pc);
            op = w[31:26];
            chk("id_pc", id_pc, exp_pc);
            chk("id_instr", id_instr, w);
            chk("opcode", 32'(opcode), 32'(op));
            chk("funct", 32'(funct), 32'(w[5:0]));
            chk("illegal", 32'(illegal),
                32'(!(op == 6'b000001 || op == 6'b000100 || op == 6'b000010)));
        end else begin
            chk("illegal_idle", 32'(illegal), 0);
        end
        if (do_flush) begin
            exp_pc   = rpc;
            issue_pc = rpc;
        end else if (id_valid && id_ready) begin
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic wait_valid(input int unsigned max);
        int unsigned n = 0;
        do begin
            step(1'b0, 32'h0);
            n++;
        end while (!s_valid && n < max);
        chk("wait_valid_timeout", 32'(s_valid), 1);
    endtask

    task automatic drain();
        ready_fix = 1'b1; gnt_fix = 1'b0; hold_resp = 1'b0;
        repeat (8) step(1'b0, 32'h0);
        chk("drain_inflight", 32'(mq.size()), 0);
        chk("drain_empty", 32'(s_valid), 0);
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        flush = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        repeat (2) step(1'b0, 32'h0);
        want_rst = 1'b1;

        // Reset release: first grant, head arrives two cycles later.
        step(1'b0, 32'h0);
        chk("first_hs", 32'(s_hs), 1);
        chk("first_addr", s_addr, RST_PC);
        chk("lat_c0_valid", 32'(s_valid), 0);
        step(1'b0, 32'h0);
        chk("lat_c1_valid", 32'(s_valid), 0);
        step(1'b0, 32'h0);
        chk("lat_c2_valid", 32'(s_valid), 1);
        chk("lat_c2_pc", s_pc, 32'h0);
        step(1'b0, 32'h0);
        chk("lat_c3_valid", 32'(s_valid), 1);
        chk("lat_c3_pc", s_pc, 32'h4);
        repeat (10) step(1'b0, 32'h0);

        // Backpressure: requests stop once two words are buffered.
        ready_fix = 1'b0;
        repeat (8) step(1'b0, 32'h0);
        chk("bp_req_low", 32'(s_req), 0);
        chk("bp_inflight", 32'(mq.size()), 0);
        chk("bp_valid", 32'(s_valid), 1);
        ready_fix = 1'b1;
        repeat (10) step(1'b0, 32'h0);

        // Flush with two requests in flight.
        drain();
        gnt_fix = 1'b1; hold_resp = 1'b1;
        repeat (3) step(1'b0, 32'h0);
        chk("two_in_flight", 32'(mq.size()), 2);
        chk("credit_req_low", 32'(s_req), 0);
        step(1'b1, 32'h100);
        hold_resp = 1'b0;
        wait_valid(20);
        chk("redirect_head_pc", s_pc, 32'h100);

        // Flush coinciding with a response, one more in flight.
        drain();
        gnt_fix = 1'b1; hold_resp = 1'b1;
        repeat (3) step(1'b0, 32'h0);
        hold_resp = 1'b0;
        step(1'b1, 32'h200);
        chk("flush_rv_inflight", 32'(mq.size()), 1);
        wait_valid(20);
        chk("ill_head_pc", s_pc, 32'h200);
        chk("ill_head_instr", s_instr, 32'hFC00_0000);
        chk("ill_flag_set", 32'(illegal), 1);
        wait_valid(20);
        chk("lw_head_pc", s_pc, 32'h204);
        chk("lw_opcode", 32'(opcode), 32'h04);
        chk("lw_illegal", 32'(illegal), 0);

        // Asynchronous reset mid-stream with the queue full.
        ready_fix = 1'b0; gnt_fix = 1'b1;
        repeat (8) step(1'b0, 32'h0);
        chk("full_valid", 32'(s_valid), 1);
        chk("full_req_low", 32'(s_req), 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(id_valid), 0);
        chk("arst_pc", id_pc, RST_PC);
        chk("arst_instr", id_instr, 0);
        chk("arst_req", 32'(req), 0);
        want_rst = 1'b0;
        repeat (2) step(1'b0, 32'h0);
        want_rst = 1'b1; ready_fix = 1'b1;
        step(1'b0, 32'h0);
        chk("resume_hs", 32'(s_hs), 1);
        chk("resume_addr", s_addr, RST_PC);

        // Randomized traffic with occasional redirects.
        gnt_rand = 1'b1; resp_rand = 1'b1; lat_rand = 1'b1; ready_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            r[1:0] = 2'b00;
            step(($urandom_range(0, 39) == 0), r);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
